// File: rtl/sdp_ram_array.sv
// Bare register-based storage for sdp_ram: one write port, asynchronous read,
// plus a synchronous whole-array clear driven by the parent.
module sdp_ram_array #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: clear wins over write; otherwise hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array state register.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM: independent write and read ports on one
// clock, registered read data, write-first on same-address collisions, and a
// synchronous active-low reset that clears both the array and dout.
module sdp_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    localparam int AW = $clog2(DEPTH);

    logic             clear;
    logic             collide;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    // Reset is active-low; any access presented during reset is discarded.
    assign clear   = ~reset;
    assign collide = wen && ren && (waddr == raddr);

    sdp_ram_array #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .clear (clear),
        .we    (wen),
        .waddr (waddr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Read data select: reset clears, collision bypasses din, idle holds.
    always_comb begin
        dout_d = dout_q;
        if (!reset) begin
            dout_d = '0;
        end else if (ren) begin
            dout_d = collide ? din : rdata;
        end
    end

    // Output register; dout comes straight from this flop.
    always_ff @(posedge clock) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sdp_ram.sv
// Directed testbench for sdp_ram (DEPTH=4, WIDTH=8).
module tb_sdp_ram;

    logic       clock;
    logic       reset;
    logic       wen;
    logic       ren;
    logic [1:0] waddr;
    logic [1:0] raddr;
    logic [7:0] din;
    logic [7:0] dout;

    int total;
    int bad;

    sdp_ram #(
        .DEPTH (4),
        .WIDTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .wen   (wen),
        .ren   (ren),
        .waddr (waddr),
        .raddr (raddr),
        .din   (din),
        .dout  (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        total++;
        assert (dout === exp) else begin
            bad++;
            $error("FAIL %s: dout=%h expected=%h", tag, dout, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic re,
                         input logic [1:0] wa, input logic [1:0] ra,
                         input logic [7:0] d);
        reset = r;
        wen   = we;
        ren   = re;
        waddr = wa;
        raddr = ra;
        din   = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 8'hFF);
        #2;

        // Reset held two edges with accesses that must be ignored.
        tick(); check("reset_edge1", 8'h00);
        tick(); check("reset_edge2", 8'h00);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 8'hFF);
        tick(); check("post_reset_addr0", 8'h00);

        // Collision write-first.
        drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 8'hA0);
        tick(); check("collide_a0", 8'hA0);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 8'hA1);
        tick(); check("collide_a1", 8'hA1);

        // Independent ports.
        drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 8'hA2);
        tick(); check("indep_r2", 8'h00);
        drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 8'hA2);
        tick(); check("indep_r0", 8'hA1);

        // Read idle holds dout; then read back the write.
        drive(1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 8'hA3);
        tick(); check("hold", 8'hA1);
        tick(); check("hold_2nd", 8'hA1);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 8'hA3);
        tick(); check("read_a3", 8'hA3);

        // Read-only with wen=0: addr0 must not take din.
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 8'hA4);
        tick(); check("readonly_r0", 8'hA1);
        drive(1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 8'hA4);
        tick(); check("mem2_zero", 8'h00);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 8'hA4);
        tick(); check("readonly_r0_again", 8'hA1);

        // Reset mid-operation discards the concurrent write.
        drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 8'h55);
        tick(); check("reset_mid", 8'h00);
        for (int a = 0; a < 4; a++) begin
            drive(1'b1, 1'b0, 1'b1, 2'd0, a[1:0], 8'h00);
            tick();
            check($sformatf("cleared_addr%0d", a), 8'h00);
        end

        // Normal operation resumes after reset.
        drive(1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 8'h5A);
        tick(); check("resume_hold", 8'h00);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 8'h00);
        tick(); check("resume_read3", 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdp_ram.md
# sdp_ram

Simple dual-port synchronous RAM: one write port and one independent read port sharing a single clock. Serves as the generic storage primitive beneath FIFOs, line buffers and register-file style blocks. Synchronous reset clears contents and output. The read path is registered, and same-address collisions resolve write-first.

## Interface
- DEPTH, default 4: number of words; must be a power of two and at least 2.
- WIDTH, default 8: bits per word.
- AW, derived, not overridable: $clog2(DEPTH), the address width.

Ports:
- clock  in  1  rising-edge clock for all logic.
- reset  in  1  reset, synchronous, active-low: sampled on rising clock; 0 = reset asserted.
- wen  in  1  write enable.
- ren  in  1  read enable.
- waddr  in  AW  write address.
- raddr  in  AW  read address.
- din  in  WIDTH  write data.
- dout  out  WIDTH  registered read data.

Width rules:
- Callers driving wider address buses are truncated to the low AW bits at the port.
- No out-of-range condition exists.

## Operation
- Storage: DEPTH × WIDTH array, mem[0..DEPTH-1].
- Reset (reset==0 at a rising edge):
  - every mem word ← 0 and dout ← 0 on that edge.
  - wen and ren are ignored while reset is low; reset has priority over all other activity.
- Write, when reset==1 and wen==1: mem[waddr] ← din at the rising edge.
- Read, when reset==1 and ren==1: dout ← mem[raddr] at the rising edge.
- Read idle, ren==0: dout holds its previous value; it never returns to 0 except via reset.
- Collision (wen & ren & waddr==raddr): write-first. dout ← din, the new data, and mem is updated with din in the same edge.
- Simultaneous read and write to different addresses are fully independent. dout returns the pre-edge content of mem[raddr].
- Writes with wen==0 never modify the array. din and waddr are don't-care then.
- No handshake and no back-pressure: every enabled access completes in one cycle.

## Timing
- Write latency: 1 edge. Data written at edge N is readable by a read issued at edge N+1, or at edge N itself via the collision bypass.
- Read latency: 1 cycle. dout is valid after the edge that sampled ren=1 and is stable until the next enabled read or reset.
- Reset value: dout = 0; all memory words = 0.
- Reset is observed on the first rising edge with reset==0. Normal operation resumes on the first edge with reset==1.
- Reset mid-operation: an access presented on the same edge as reset==0 is discarded.
- All outputs come directly from flops; there is no combinational path from inputs to dout.

## Structure
- No shared package is needed. AW is a localparam computed from DEPTH inside the module.
- Optional sub-module: sdp_ram_array, the bare storage with write port and asynchronous read. The top level adds the reset clear, collision bypass mux and dout register.
- Keep the reset clear as an explicit per-word loop so the array stays synthesizable as registers for small DEPTH.

## Test plan
- Reset: hold reset=0 for 2 edges with wen=ren=1 and din=0xFF -> dout=0x00; a later read of addr0 returns 0x00.
- Collision: with DEPTH=4 and WIDTH=8, apply wen=ren=1, waddr=raddr=0, din=0xA0 -> dout=0xA0 after 1 edge. Next cycle, same addresses with din=0xA1 -> dout=0xA1.
- Independent ports: wen=ren=1, waddr=1, raddr=2, din=0xA2 -> dout=0x00 (cleared word). Next, waddr=1, raddr=0 -> dout=0xA1.
- Hold: wen=1, ren=0, waddr=1, din=0xA3 -> dout stays 0xA1. Then wen=0, ren=1, raddr=1 -> dout=0xA3.
- Read-only: wen=0, ren=1, raddr=0, din=0xA4 -> dout=0xA1, and mem[2] remains 0x00.
- Reset mid-operation: after the above, assert reset=0 for 1 edge with wen=1, waddr=3, din=0x55 -> dout=0x00. Reads of addr0..3 all return 0x00.
